// File: rtl/operand_forward_unit_if.sv
// Decode-side operand bus between ID/register file and the forwarding unit feeding EXEStage.
// The master drives the ID instruction and stage results; the slave returns the ID/EX operands.
interface operand_forward_unit_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic [DATA_W-1:0]     rf_data1;
  logic [DATA_W-1:0]     rf_data2;
  logic                  flush;
  logic [DATA_W-1:0]     ex_result;
  logic [DATA_W-1:0]     mem_result;
  logic [DATA_W-1:0]     wb_result;
  logic                  stall;
  logic [DATA_W-1:0]     bus1;
  logic [DATA_W-1:0]     bus2;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
    output rf_data1, rf_data2, flush, ex_result, mem_result, wb_result,
    input  stall, bus1, bus2, ex_valid, ex_rd
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
    input  rf_data1, rf_data2, flush, ex_result, mem_result, wb_result,
    output stall, bus1, bus2, ex_valid, ex_rd
  );
endinterface

// File: rtl/operand_forward_unit.sv
// Operand forwarding for EXEStage: tracks EX/MEM/WB destination tags, picks the newest producer,
// stalls on load-use and registers Bus1/Bus2. Optional FWD_STALL_STATS_EN adds debug counters.
module operand_forward_unit #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  operand_forward_unit_if.slave fwd_io
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  load;
    logic [REG_ADDR_W-1:0] rd;
  } slot_t;

  slot_t             ex_q, ex_d, mem_q, wb_q;
  logic [DATA_W-1:0] bus1_q, bus1_d, bus2_q, bus2_d;
  logic [DATA_W-1:0] op1, op2;
  logic              fwd1, fwd2;
  logic              ex_hit1, ex_hit2;
  logic              stall, issue;

  // r0 is hard-wired zero, so a write to it never satisfies a read.
  function automatic logic hit(input slot_t s, input logic [REG_ADDR_W-1:0] src,
                               input logic use_src);
    return s.valid && s.we && (s.rd == src) && (src != '0) && use_src;
  endfunction

  // Returns {forwarded, value}; the youngest producer wins.
  function automatic logic [DATA_W:0] pick(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  use_src,
    input logic [DATA_W-1:0]     rf_val,
    input slot_t                 ex_s,
    input slot_t                 mem_s,
    input slot_t                 wb_s,
    input logic [DATA_W-1:0]     ex_val,
    input logic [DATA_W-1:0]     mem_val,
    input logic [DATA_W-1:0]     wb_val
  );
    if (hit(ex_s, src, use_src))  return {1'b1, ex_val};
    if (hit(mem_s, src, use_src)) return {1'b1, mem_val};
    if (hit(wb_s, src, use_src))  return {1'b1, wb_val};
    return {1'b0, rf_val};
  endfunction

  always_comb begin
    {fwd1, op1} = pick(fwd_io.id_rs1, fwd_io.id_use_rs1, fwd_io.rf_data1, ex_q, mem_q, wb_q,
                       fwd_io.ex_result, fwd_io.mem_result, fwd_io.wb_result);
    {fwd2, op2} = pick(fwd_io.id_rs2, fwd_io.id_use_rs2, fwd_io.rf_data2, ex_q, mem_q, wb_q,
                       fwd_io.ex_result, fwd_io.mem_result, fwd_io.wb_result);
    ex_hit1 = hit(ex_q, fwd_io.id_rs1, fwd_io.id_use_rs1);
    ex_hit2 = hit(ex_q, fwd_io.id_rs2, fwd_io.id_use_rs2);

    // A load in EX has no data yet; wait one cycle so it can come from MEM.
    stall = fwd_io.id_valid & ~fwd_io.flush & ex_q.load & (ex_hit1 | ex_hit2);
    issue = fwd_io.id_valid & ~stall & ~fwd_io.flush;

    ex_d = '0;
    if (issue) begin
      ex_d.valid = 1'b1;
      ex_d.we    = fwd_io.id_reg_write;
      ex_d.load  = fwd_io.id_mem_read;
      ex_d.rd    = fwd_io.id_rd;
    end

    bus1_d = issue ? op1 : bus1_q;
    bus2_d = issue ? op2 : bus2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      bus1_q <= '0;
      bus2_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= ex_q;
      wb_q   <= mem_q;
      bus1_q <= bus1_d;
      bus2_q <= bus2_d;
    end
  end

  assign fwd_io.stall    = stall;
  assign fwd_io.bus1     = bus1_q;
  assign fwd_io.bus2     = bus2_q;
  assign fwd_io.ex_valid = ex_q.valid;
  assign fwd_io.ex_rd    = ex_q.rd;

`ifdef FWD_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]  fwd_inc;
  logic [16:0] fwd_sum;

  always_comb begin
    fwd_inc     = {1'b0, issue & fwd1} + {1'b0, issue & fwd2};
    fwd_sum     = {1'b0, fwd_cnt_q} + {15'd0, fwd_inc};
    fwd_cnt_d   = fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Scoreboard bench for operand_forward_unit: directed scenarios plus random traffic,
// checked against a queue model of in-flight instructions.
module tb_operand_forward_unit;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_forward_unit_if #(.DATA_W(DW), .REG_ADDR_W(AW)) fwd_if ();

  operand_forward_unit #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fwd_io (fwd_if)
  );

  typedef struct {
    logic       valid;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u1;
    logic       u2;
    logic [2:0] rd;
    logic       we;
    logic       ld;
    logic [15:0] res;
  } instr_t;

  typedef struct {
    logic        valid;
    logic [2:0]  rd;
    logic        we;
    logic        ld;
    logic [15:0] res;
  } slot_t;

  typedef struct {
    logic [15:0] b1;
    logic [15:0] b2;
    logic [2:0]  rd;
  } exp_t;

  slot_t pipe[$];  // [0] = EX, [1] = MEM, [2] = WB
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  function automatic slot_t bubble();
    slot_t s;
    s = '{valid: 1'b0, rd: 3'd0, we: 1'b0, ld: 1'b0, res: 16'($urandom)};
    return s;
  endfunction

  function automatic void clear_model();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(bubble());
  endfunction

  // Index of the youngest in-flight writer of src, or -1.
  function automatic int producer(logic [2:0] src, logic use_s);
    if (!use_s || src == 3'd0) return -1;
    for (int i = 0; i < pipe.size(); i++)
      if (pipe[i].valid && pipe[i].we && pipe[i].rd == src) return i;
    return -1;
  endfunction

  function automatic instr_t mk(logic [2:0] rs1, logic [2:0] rs2, logic u1, logic u2,
                                logic [2:0] rd, logic we, logic ld, logic [15:0] res);
    instr_t t;
    t = '{valid: 1'b1, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, we: we, ld: ld, res: res};
    return t;
  endfunction

  task automatic step(input instr_t in, input logic fl, input logic [15:0] d1,
                      input logic [15:0] d2, output logic stalled);
    int    p1, p2;
    logic  exp_stall, iss;
    exp_t  e;
    slot_t s;
    @(negedge clk);
    fwd_if.id_valid     = in.valid;
    fwd_if.id_rs1       = in.rs1;
    fwd_if.id_rs2       = in.rs2;
    fwd_if.id_use_rs1   = in.u1;
    fwd_if.id_use_rs2   = in.u2;
    fwd_if.id_rd        = in.rd;
    fwd_if.id_reg_write = in.we;
    fwd_if.id_mem_read  = in.ld;
    fwd_if.rf_data1     = d1;
    fwd_if.rf_data2     = d2;
    fwd_if.flush        = fl;
    // A load's ALU output is its address, never its data.
    fwd_if.ex_result    = pipe[0].ld ? 16'($urandom) : pipe[0].res;
    fwd_if.mem_result   = pipe[1].res;
    fwd_if.wb_result    = pipe[2].res;
    p1 = producer(in.rs1, in.u1);
    p2 = producer(in.rs2, in.u2);
    exp_stall = in.valid && !fl && pipe[0].ld && (p1 == 0 || p2 == 0);
    iss = in.valid && !fl && !exp_stall;
    #1;
    chk("stall", 32'(fwd_if.stall), 32'(exp_stall));
    if (iss) begin
      e.b1 = (p1 < 0) ? d1 : pipe[p1].res;
      e.b2 = (p2 < 0) ? d2 : pipe[p2].res;
      e.rd = in.rd;
      exp_q.push_back(e);
    end
    stalled = exp_stall;
    @(posedge clk);
    if (iss) s = '{valid: 1'b1, rd: in.rd, we: in.we, ld: in.ld, res: in.res};
    else     s = bubble();
    pipe.push_front(s);
    void'(pipe.pop_back());
  endtask

  task automatic do_reset();
    @(negedge clk);
    fwd_if.id_valid = 1'b0;
    fwd_if.flush    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus1", 32'(fwd_if.bus1), 32'h0);
    chk("rst_bus2", 32'(fwd_if.bus2), 32'h0);
    chk("rst_ex_valid", 32'(fwd_if.ex_valid), 32'h0);
    chk("rst_stall", 32'(fwd_if.stall), 32'h0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops an expectation whenever EX holds a real instruction; otherwise Bus must hold.
  initial begin
    logic [15:0] last1, last2;
    exp_t e;
    last1 = '0;
    last2 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last1 = '0;
        last2 = '0;
      end else if (fwd_if.ex_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 32'(fwd_if.ex_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("bus1", 32'(fwd_if.bus1), 32'(e.b1));
          chk("bus2", 32'(fwd_if.bus2), 32'(e.b2));
          chk("ex_rd", 32'(fwd_if.ex_rd), 32'(e.rd));
          last1 = e.b1;
          last2 = e.b2;
        end
      end else begin
        chk("hold_bus1", 32'(fwd_if.bus1), 32'(last1));
        chk("hold_bus2", 32'(fwd_if.bus2), 32'(last2));
      end
    end
  end

  initial begin
    instr_t nop, cur;
    logic   st;
    logic   fl;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    nop.valid = 1'b0;
    fwd_if.id_valid = 1'b0;   fwd_if.id_rs1 = '0;       fwd_if.id_rs2 = '0;
    fwd_if.id_use_rs1 = 1'b0; fwd_if.id_use_rs2 = 1'b0; fwd_if.id_rd = '0;
    fwd_if.id_reg_write = 1'b0; fwd_if.id_mem_read = 1'b0;
    fwd_if.rf_data1 = '0;     fwd_if.rf_data2 = '0;     fwd_if.flush = 1'b0;
    fwd_if.ex_result = '0;    fwd_if.mem_result = '0;   fwd_if.wb_result = '0;
    rst_n = 1'b1;
    clear_model();
    do_reset();

    // Load-use on r4, then EX forward of r3.
    step(mk(0, 0, 0, 0, 4, 1, 1, 16'hBEEF), 1'b0, 16'h0, 16'h0, st);
    step(mk(4, 0, 1, 0, 5, 1, 0, 16'h0123), 1'b0, 16'h0, 16'h0, st);
    chk("loaduse_stalled", 32'(st), 32'h1);
    step(mk(4, 0, 1, 0, 5, 1, 0, 16'h0123), 1'b0, 16'h0, 16'h0, st);
    chk("loaduse_one_cycle", 32'(st), 32'h0);
    step(mk(0, 0, 0, 0, 3, 1, 0, 16'h0010), 1'b0, 16'h0, 16'h0, st);
    step(mk(3, 0, 1, 0, 6, 1, 0, 16'h0042), 1'b0, 16'h0000, 16'h0, st);
`ifdef FWD_STALL_STATS_EN
    #1;
    chk("stall_cnt", 32'(dut.stall_cnt_q), 32'd1);
    chk("fwd_cnt", 32'(dut.fwd_cnt_q), 32'd2);
`endif

    // Priority: WB/MEM/EX all write r2.
    step(mk(0, 0, 0, 0, 2, 1, 0, 16'h1111), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 0, 0, 0, 2, 1, 0, 16'h2222), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 0, 0, 0, 2, 1, 0, 16'h3333), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 2, 0, 1, 7, 0, 0, 16'h0), 1'b0, 16'h0, 16'hAAAA, st);
    step(mk(0, 0, 0, 0, 2, 1, 0, 16'h1111), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 0, 0, 0, 2, 1, 0, 16'h2222), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 0, 0, 0, 5, 1, 0, 16'h3333), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 2, 0, 1, 7, 0, 0, 16'h0), 1'b0, 16'h0, 16'hAAAA, st);

    // r0 never forwards; flush beats load-use stall.
    step(mk(0, 0, 0, 0, 0, 1, 0, 16'h5555), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 0, 1, 0, 1, 1, 0, 16'h0), 1'b0, 16'h0000, 16'h0, st);
    step(mk(0, 0, 0, 0, 6, 1, 1, 16'hCAFE), 1'b0, 16'h0, 16'h0, st);
    step(mk(6, 0, 1, 0, 1, 1, 0, 16'h0), 1'b1, 16'h0, 16'h0, st);
    chk("flush_no_stall", 32'(st), 32'h0);

    // Reset with every slot busy: the next issue sees only the register file.
    step(mk(0, 0, 0, 0, 1, 1, 0, 16'h0101), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 0, 0, 0, 2, 1, 0, 16'h0202), 1'b0, 16'h0, 16'h0, st);
    step(mk(0, 0, 0, 0, 1, 1, 1, 16'h0303), 1'b0, 16'h0, 16'h0, st);
    do_reset();
    step(mk(1, 2, 1, 1, 3, 1, 0, 16'h0), 1'b0, 16'h0AAA, 16'h0BBB, st);

    st = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!st) begin
        cur = mk(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 3'($urandom_range(0, 3)), ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 99) < 30), 16'($urandom));
        cur.valid = ($urandom_range(0, 99) < 85);
      end
      fl = ($urandom_range(0, 9) == 0);
      step(cur, fl, 16'($urandom), 16'($urandom), st);
      if (i == 700) begin
        do_reset();
        st = 1'b0;
      end
    end

    step(nop, 1'b0, 16'h0, 16'h0, st);
    step(nop, 1'b0, 16'h0, 16'h0, st);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
